div_ctrl: RTL

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_ctrl_pkg.sv | 22 ++
 rtl/div_ctrl_hilo_reg.sv | 37 +++
 rtl/div_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the divide/MTHI/MTLO sequencer.
package div_ctrl_pkg;

  localparam int DATA_W          = 32;
  localparam int TIMEOUT_DEFAULT = 40;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_MTHI = 2'b01,
    OP_MTLO = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_FIN    = 3'd4
  } state_e;

endpackage

// File: rtl/div_ctrl_hilo_reg.sv
// Architectural HI/LO storage: two independent 32-bit registers with
// separate write enables and synchronous reset.
module hilo_reg
  import div_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we_hi,
  input  logic              we_lo,
  input  logic [DATA_W-1:0] d_hi,
  input  logic [DATA_W-1:0] d_lo,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  logic [DATA_W-1:0] hi_r;
  logic [DATA_W-1:0] lo_r;

  // HI/LO register update
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_r <= {DATA_W{1'b0}};
      lo_r <= {DATA_W{1'b0}};
    end else begin
      if (we_hi) begin
        hi_r <= d_hi;
      end
      if (we_lo) begin
        lo_r <= d_lo;
      end
    end
  end

  assign hi = hi_r;
  assign lo = lo_r;

endmodule

// File: rtl/div_ctrl.sv
// Sequencer between the control unit and an external divider: launches
// divides, waits with a timeout, and commits results or MTHI/MTLO into HI/LO.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              div_start,
  output logic [DATA_W-1:0] div_a,
  output logic [DATA_W-1:0] div_b,
  input  logic              div_stop,
  input  logic              div_zero,
  input  logic [DATA_W-1:0] div_hi,
  input  logic [DATA_W-1:0] div_lo,
  output logic              busy,
  output logic              done,
  output logic              div_zero_exc,
  output logic              timeout_err,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e            state_r;
  state_e            state_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic [CNT_W-1:0]  cnt_inc_s;
  op_e               op_s;
  logic              cap_s;
  logic              we_hi_s;
  logic              we_lo_s;
  logic [DATA_W-1:0] d_hi_s;
  logic [DATA_W-1:0] d_lo_s;
  logic              zexc_nxt_s;
  logic              tmo_nxt_s;

  logic              div_start_r;
  logic              busy_r;
  logic              done_r;
  logic              div_zero_exc_r;
  logic              timeout_err_r;
  logic [DATA_W-1:0] div_a_r;
  logic [DATA_W-1:0] div_b_r;

  assign op_s      = op_e'(op);
  assign cnt_inc_s = cnt_r + CNT_W'(1);

  // Next-state, counter and HI/LO write decode
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    cap_s       = 1'b0;
    we_hi_s     = 1'b0;
    we_lo_s     = 1'b0;
    d_hi_s      = div_hi;
    d_lo_s      = div_lo;
    zexc_nxt_s  = 1'b0;
    tmo_nxt_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          case (op_s)
            OP_DIV: begin
              cap_s       = 1'b1;
              state_nxt_s = ST_LAUNCH;
            end
            OP_MTHI: begin
              we_hi_s     = 1'b1;
              d_hi_s      = a;
              state_nxt_s = ST_FIN;
            end
            OP_MTLO: begin
              we_lo_s     = 1'b1;
              d_lo_s      = a;
              state_nxt_s = ST_FIN;
            end
            default: begin
              state_nxt_s = ST_IDLE;
            end
          endcase
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        cnt_nxt_s   = {CNT_W{1'b0}};
        state_nxt_s = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_nxt_s = cnt_inc_s;
        // cnt_r == 0 marks the first WAIT cycle, where div_stop may still be stale
        if ((cnt_r != {CNT_W{1'b0}}) && div_stop) begin
          state_nxt_s = ST_WRITE;
        end else if (cnt_inc_s == CNT_W'(TIMEOUT)) begin
          tmo_nxt_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_WRITE: begin
        if (div_zero) begin
          zexc_nxt_s = 1'b1;
        end else begin
          we_hi_s = 1'b1;
          we_lo_s = 1'b1;
        end
        state_nxt_s = ST_FIN;
      end
      ST_FIN: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, counter, operand capture and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      cnt_r          <= {CNT_W{1'b0}};
      div_start_r    <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      div_zero_exc_r <= 1'b0;
      timeout_err_r  <= 1'b0;
      div_a_r        <= {DATA_W{1'b0}};
      div_b_r        <= {DATA_W{1'b0}};
    end else begin
      state_r        <= state_nxt_s;
      cnt_r          <= cnt_nxt_s;
      div_start_r    <= (state_nxt_s == ST_LAUNCH);
      busy_r         <= (state_nxt_s != ST_IDLE);
      done_r         <= (state_nxt_s == ST_FIN);
      div_zero_exc_r <= zexc_nxt_s;
      timeout_err_r  <= tmo_nxt_s;
      if (cap_s) begin
        div_a_r <= a;
        div_b_r <= b;
      end
    end
  end

  hilo_reg u_hilo (
    .clk   (clk),
    .reset (reset),
    .we_hi (we_hi_s),
    .we_lo (we_lo_s),
    .d_hi  (d_hi_s),
    .d_lo  (d_lo_s),
    .hi    (hi),
    .lo    (lo)
  );

  assign div_start    = div_start_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign div_zero_exc = div_zero_exc_r;
  assign timeout_err  = timeout_err_r;
  assign div_a        = div_a_r;
  assign div_b        = div_b_r;

endmodule
